// File: rtl/draw_rect_engine_pkg.sv
// Shared constants, FSM state type and instruction layout helper for the
// rectangle draw engine and its scan cursor.
package draw_rect_engine_pkg;

  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOUR_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_RESULT_W = 32;
  localparam int DEF_INSTR_W  = 32;

  localparam int OPCODE_W = 4;
  localparam int PAD_W    = 9;

  localparam logic [OPCODE_W-1:0] OPCODE_PLOT = 4'd1;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADVANCE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  // Plot instruction is {opcode, pad, plot bit, colour, y, x}.
  function automatic int instr_width(input int colour_w, input int y_w, input int x_w);
    return OPCODE_W + PAD_W + 1 + colour_w + y_w + x_w;
  endfunction

endpackage

// File: rtl/draw_rect_engine_scan_cursor.sv
// Row-major col/row cursor over a w x h rectangle; in outline mode interior
// rows jump from the left edge straight to the right edge.
module rect_scan_cursor
  import draw_rect_engine_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           clear,
  input  logic           step,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  input  logic           mode,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           last
);

  localparam logic [X_W-1:0] ONE_X = X_W'(1);
  localparam logic [Y_W-1:0] ONE_Y = Y_W'(1);

  logic [X_W-1:0] r_col;
  logic [Y_W-1:0] r_row;
  logic           w_col_end;
  logic           w_row_end;
  logic           w_interior;

  assign w_col_end  = (r_col == w - ONE_X);
  assign w_row_end  = (r_row == h - ONE_Y);
  // w==1 or h==1 never reaches the jump, so outline degenerates to fill.
  assign w_interior = (r_row != '0) && !w_row_end;

  assign col  = r_col;
  assign row  = r_row;
  assign last = w_col_end && w_row_end;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (step) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + ONE_Y;
      end else if (mode == MODE_OUTLINE && w_interior && r_col == '0) begin
        r_col <= w - ONE_X;
      end else begin
        r_col <= r_col + ONE_X;
      end
    end
  end

endmodule

// File: rtl/draw_rect_engine.sv
// Rectangle rasteriser: walks a latched rectangle, clips against the screen and
// issues one plot instruction per visible pixel to the draw processor.
module draw_rect_engine
  import draw_rect_engine_pkg::*;
#(
  parameter int              X_W      = DEF_X_W,
  parameter int              Y_W      = DEF_Y_W,
  parameter int              COLOUR_W = DEF_COLOUR_W,
  parameter int              SCREEN_W = DEF_SCREEN_W,
  parameter int              SCREEN_H = DEF_SCREEN_H,
  parameter logic [3:0]      OPCODE   = OPCODE_PLOT,
  parameter int              RESULT_W = DEF_RESULT_W,
  parameter int              INSTR_W  = DEF_INSTR_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [X_W-1:0]      rect_x,
  input  logic [Y_W-1:0]      rect_y,
  input  logic [X_W-1:0]      rect_w,
  input  logic [Y_W-1:0]      rect_h,
  input  logic [COLOUR_W-1:0] rect_colour,
  input  logic                mode,
  output logic                finished,
  input  logic                finished_dp,
  input  logic [RESULT_W-1:0] result_dp,
  output logic                start_dp,
  output logic [INSTR_W-1:0]  instruction_dp
);

  if (INSTR_W != instr_width(COLOUR_W, Y_W, X_W)) begin : g_bad_instr_w
    $error("INSTR_W must equal 4+9+1+COLOUR_W+Y_W+X_W");
  end

  localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCREEN_H);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_finished;
  logic [INSTR_W-1:0]  r_instr;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [X_W-1:0]      r_w;
  logic [Y_W-1:0]      r_h;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_mode;

  logic                w_accept;
  logic                w_step;
  logic                w_load;
  logic [X_W-1:0]      w_col;
  logic [Y_W-1:0]      w_row;
  logic                w_last;
  logic [X_W:0]        w_px_x;
  logic [Y_W:0]        w_px_y;
  logic                w_on_screen;
  logic [INSTR_W-1:0]  w_instr;
  logic                w_unused_result;

  assign w_unused_result = ^result_dp;

  rect_scan_cursor #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_cursor (
    .clock  (clock),
    .resetn (resetn),
    .clear  (w_accept),
    .step   (w_step),
    .w      (r_w),
    .h      (r_h),
    .mode   (r_mode),
    .col    (w_col),
    .row    (w_row),
    .last   (w_last)
  );

  // One extra bit of headroom so a sum past the edge clips instead of wrapping.
  assign w_px_x      = {1'b0, r_x} + {1'b0, w_col};
  assign w_px_y      = {1'b0, r_y} + {1'b0, w_row};
  assign w_on_screen = (w_px_x < SCR_W_L) && (w_px_y < SCR_H_L);
  assign w_instr     = {OPCODE, 9'd0, 1'b1, r_colour, w_px_y[Y_W-1:0], w_px_x[X_W-1:0]};

  assign finished       = r_finished;
  assign start_dp       = (r_state == S_ISSUE);
  assign instruction_dp = r_instr;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_load       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_finished && start && !abort) begin
          w_accept     = 1'b1;
          w_next_state = (rect_w == '0 || rect_h == '0) ? S_DONE : S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (w_on_screen) begin
          w_load       = 1'b1;
          w_next_state = S_ISSUE;
        end else if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      S_ISSUE: w_next_state = S_ARM;
      // finished_dp may still be high from the previous pixel here.
      S_ARM:   w_next_state = S_WAIT;
      S_WAIT: begin
        if (finished_dp) begin
          if (w_last) begin
            w_next_state = S_DONE;
          end else begin
            w_step       = 1'b1;
            w_next_state = S_ADVANCE;
          end
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) begin
      w_next_state = S_IDLE;
      w_step       = 1'b0;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_finished <= 1'b1;
      r_instr    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_colour   <= '0;
      r_mode     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_finished <= 1'b0;
        r_x        <= rect_x;
        r_y        <= rect_y;
        r_w        <= rect_w;
        r_h        <= rect_h;
        r_colour   <= rect_colour;
        r_mode     <= mode;
      end else if (r_state == S_IDLE || abort) begin
        r_finished <= 1'b1;
      end
      if (w_load) begin
        r_instr <= w_instr;
      end
    end
  end

endmodule
